key_event_scanner: RTL

Parametrised successor to the single-key priority scanner. It scans NUM_KEYS raw piano keys and debounces each one on a shared sample tick. The full held-key bitmap and a popcount are exported. Every debounced press and release becomes an event in a valid/ready FIFO, and the block also tracks a last-note-priority mono key for the tone generator, replacing lowest-index priority.

---
 rtl/piano_pkg.sv | 11 +
 rtl/key_debounce_cell.sv | 52 +++++
 rtl/key_event_scanner.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/piano_pkg.sv
// Shared helpers for the piano key scanner family: ID sizing and build defaults.
package piano_pkg;

  localparam int unsigned DefaultClkHz = 50_000_000;

  // Key IDs run 1..n with 0 reserved for "none", so n+1 codes are needed.
  function automatic int unsigned id_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-FF synchroniser, tick-sampled debounce counter, stable level and flip pulse.
module key_debounce_cell #(
  parameter int unsigned DEBOUNCE_SAMPLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic tick,
  output logic held,
  output logic flip
);

  localparam int unsigned CntW = (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES) : 1;

  logic            meta_q, sync_q, held_q, held_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      held_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
      held_q <= held_d;
      cnt_q  <= cnt_d;
    end
  end

  // Any agreeing sample restarts the run of disagreeing ones.
  always_comb begin
    cnt_d  = cnt_q;
    held_d = held_q;
    flip   = 1'b0;
    if (tick) begin
      if (sync_q == held_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntW'(DEBOUNCE_SAMPLES - 1)) begin
        held_d = ~held_q;
        cnt_d  = '0;
        flip   = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign held = held_q;

endmodule

// File: rtl/key_event_scanner.sv
// Debounced multi-key scanner: held bitmap, popcount, press/release event FIFO
// and last-note-priority mono key.
module key_event_scanner
  import piano_pkg::*;
#(
  parameter int unsigned NUM_KEYS         = 12,
  parameter int unsigned CLK_HZ           = DefaultClkHz,
  parameter int unsigned SAMPLE_HZ        = 1000,
  parameter int unsigned DEBOUNCE_SAMPLES = 20,
  parameter int unsigned FIFO_DEPTH       = 8,
  localparam int unsigned ID_W            = id_width(NUM_KEYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys_in_raw,
  output logic [NUM_KEYS-1:0] keys_held,
  output logic [ID_W-1:0]     held_count,
  output logic [ID_W-1:0]     mono_key_id,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [ID_W-1:0]     evt_key_id,
  output logic                evt_is_press,
  output logic                overflow,
  input  logic                clear_overflow
);

  localparam int unsigned Div   = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned PresW = $clog2(Div);
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  typedef struct packed {
    logic [ID_W-1:0] key_id;
    logic            is_press;
  } key_event_t;

  logic [PresW-1:0]    presc_q;
  logic                tick;
  logic [NUM_KEYS-1:0] held_q, flip, held_next;
  logic [NUM_KEYS-1:0] pend_q, pend_d, type_q, type_d;
  logic [ID_W-1:0]     count_q, count_d, mono_q, mono_d;
  logic                overflow_q, overflow_d, annihilate;
  logic [PtrW-1:0]     wptr_q, rptr_q;
  key_event_t          mem_q [FIFO_DEPTH];
  key_event_t          push_evt, head;
  logic [NUM_KEYS-1:0] grant_oh;
  logic                grant_valid, empty, full, push, pop;

  // Sample-tick prescaler
  assign tick = (presc_q == PresW'(Div - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PresW'(1);
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_cell #(
      .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .raw (keys_in_raw[i]),
      .tick(tick),
      .held(held_q[i]),
      .flip(flip[i])
    );
  end

  assign held_next = held_q ^ flip;

  // Lowest-index pending key wins the single enqueue slot.
  always_comb begin
    grant_valid = 1'b0;
    grant_oh    = '0;
    push_evt    = '0;
    for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        grant_valid       = 1'b1;
        grant_oh          = '0;
        grant_oh[i]       = 1'b1;
        push_evt.key_id   = ID_W'(i + 1);
        push_evt.is_press = type_q[i];
      end
    end
  end

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                 (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign pop   = !empty && evt_ready;
  assign push  = grant_valid && (!full || pop);

  // A flip that lands on a still-pending event cancels both and flags the loss.
  always_comb begin
    pend_d     = pend_q & ~(push ? grant_oh : '0);
    type_d     = type_q;
    annihilate = 1'b0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      if (flip[i]) begin
        if (pend_d[i]) begin
          pend_d[i]  = 1'b0;
          annihilate = 1'b1;
        end else begin
          pend_d[i] = 1'b1;
          type_d[i] = held_next[i];
        end
      end
    end
  end

  always_comb begin
    logic [NUM_KEYS-1:0] press, release_k;
    logic                mono_released;
    press         = flip & held_next;
    release_k     = flip & ~held_next;
    mono_released = 1'b0;
    mono_d        = mono_q;
    count_d       = '0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      count_d = count_d + ID_W'(held_next[i]);
      if (release_k[i] && (mono_q == ID_W'(i + 1))) mono_released = 1'b1;
    end
    if (|press) begin
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        if (press[i]) mono_d = ID_W'(i + 1);
      end
    end else if (mono_released) begin
      mono_d = '0;
      for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
        if (held_next[i]) mono_d = ID_W'(i + 1);
      end
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (annihilate) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      type_q     <= '0;
      count_q    <= '0;
      mono_q     <= '0;
      overflow_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      pend_q     <= pend_d;
      type_q     <= type_d;
      count_q    <= count_d;
      mono_q     <= mono_d;
      overflow_q <= overflow_d;
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AddrW-1:0]] <= push_evt;
  end

  assign head         = mem_q[rptr_q[AddrW-1:0]];
  assign evt_valid    = !empty;
  assign evt_key_id   = evt_valid ? head.key_id : '0;
  assign evt_is_press = evt_valid & head.is_press;
  assign keys_held    = held_q;
  assign held_count   = count_q;
  assign mono_key_id  = mono_q;
  assign overflow     = overflow_q;

endmodule
